fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Latency: none, wires only.
// Backpressure: request side uses valid/ready; response side is valid-only.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding imem fetch, IF/ID register, hold buffer, jump redirect.
// Latency: instruction reaches IF/ID on the edge its response arrives (or stall releases).
// Backpressure: stall_i freezes IF/ID; a response arriving under stall is parked in a
//   hold buffer and no new request issues until it is delivered.
// Define BRANCH_DELAY_SLOT_EN to make jumps redirect after one delay-slot instruction
//   instead of squashing the in-flight fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [31:0]   jump_target_i,
  fetch_stage_if.master imem,
  output logic [31:0]   if_id_instr,
  output logic [31:0]   if_id_pc_plus4,
  output logic          if_id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_q, hold_d;

  logic        flush_hon;
  logic        squash;
  logic        deliver;
  logic [31:0] deliver_dat;
  logic [31:0] next_pc;
  logic        req_vld;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

  // Fetch FSM, IF/ID update and PC selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    hold_d      = hold_q;
    deliver     = 1'b0;
    deliver_dat = 32'h0;
    req_vld     = 1'b0;
    next_pc     = pc_q + 32'd4;
    flush_hon   = flush_i && !stall_i;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    // A jump never kills the in-flight instruction: it is the delay slot.
    squash      = 1'b0;
`else
    squash      = flush_hon;
`endif

    // Any unstalled cycle without a delivery leaves a bubble behind.
    if (!stall_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        req_vld = 1'b1;
        if (imem.imem_req_ready) begin
          // An accepted request for a squashed path must still be drained.
          state_d = squash ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (squash) begin
          state_d = imem.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem.imem_rsp_valid) begin
          if (stall_i) begin
            hold_d  = imem.imem_rsp_data;
            state_d = S_HOLD;
          end else begin
            deliver     = 1'b1;
            deliver_dat = imem.imem_rsp_data;
            state_d     = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          state_d = S_REQ;
          if (!squash) begin
            deliver     = 1'b1;
            deliver_dat = hold_q;
          end
        end
      end
      S_DROP: begin
        if (imem.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

`ifdef BRANCH_DELAY_SLOT_EN
    // A jump seen in the same cycle as the delay slot lands redirects at once.
    if (flush_hon) begin
      next_pc = jump_target_i;
    end else if (pend_vld_q) begin
      next_pc = pend_tgt_q;
    end
    if (deliver) begin
      pend_vld_d = 1'b0;
    end else if (flush_hon) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = jump_target_i;
    end
`endif

    if (squash) begin
      pc_d = jump_target_i;
    end else if (deliver) begin
      pc_d = next_pc;
    end

    if (deliver) begin
      instr_d = deliver_dat;
      pc4_d   = pc_q + 32'd4;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous reset to the boot PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  // Pending delay-slot redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`endif

  assign imem.imem_req_valid = req_vld;
  assign imem.imem_addr      = pc_q;
  assign if_id_instr         = instr_q;
  assign if_id_pc_plus4      = pc4_q;
  assign if_id_valid         = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, all
// outputs compared every cycle against a transaction-level model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] jump_target_i;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .jump_target_i (jump_target_i),
    .imem          (bus),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: a fetch either is outstanding, is parked, or neither.
  logic [31:0] m_pc, m_instr, m_pc4, m_held_data, m_pend_tgt;
  logic        m_valid, m_out, m_out_drop, m_held, m_pend;

  // Memory environment
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        fixed_data_en;
  logic        force_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (fixed_data_en) return 32'h2108_0001;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_out = 0; m_out_drop = 0; m_held = 0; m_held_data = 0;
    m_pend = 0; m_pend_tgt = 0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic [31:0] tg,
                            input logic rdy, input logic rv, input logic [31:0] rd);
    logic hon, req, dlv;
    logic [31:0] dd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hon = fl && !st;
    req = !m_out && !m_held;
    dlv = 0;
    dd  = 0;
    if (m_out && rv) begin
      m_out = 0;
`ifdef BRANCH_DELAY_SLOT_EN
      if (!m_out_drop) begin
`else
      if (!m_out_drop && !hon) begin
`endif
        if (st) begin m_held = 1; m_held_data = rd; end
        else begin dlv = 1; dd = rd; end
      end
      m_out_drop = 0;
    end else if (m_held && !st) begin
      m_held = 0;
`ifdef BRANCH_DELAY_SLOT_EN
      dlv = 1; dd = m_held_data;
`else
      if (!hon) begin dlv = 1; dd = m_held_data; end
`endif
    end
    if (req && rdy) begin
      m_out = 1;
      m_out_drop = 0;
    end
    if (!st) m_valid = 0;
    if (dlv) begin m_instr = dd; m_pc4 = m_pc + 4; m_valid = 1; end
`ifdef BRANCH_DELAY_SLOT_EN
    if (dlv) begin
      if (hon) m_pc = tg;
      else if (m_pend) m_pc = m_pend_tgt;
      else m_pc = m_pc + 4;
      m_pend = 0;
    end else if (hon) begin
      m_pend = 1; m_pend_tgt = tg;
    end
`else
    if (hon) begin
      m_pc = tg;
      if (m_out) m_out_drop = 1;
    end else if (dlv) begin
      m_pc = m_pc + 4;
    end
`endif
  endtask

  // One clock: drive inputs now, advance at the edge, return 1ns after it.
  task automatic cycle(input logic st, input logic fl, input logic [31:0] tg,
                       input logic rdy, input int lat);
    logic acc;
    logic [31:0] acc_addr;
    stall_i = st; flush_i = fl; jump_target_i = tg;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_data(mem_addr);
      end
    end
    if (force_rsp) bus.imem_rsp_valid = 1'b1;
    acc      = rst_n && bus.imem_req_valid && rdy;
    acc_addr = bus.imem_addr;
    @(posedge clk);
    model_step(stall_i, flush_i, jump_target_i, bus.imem_req_ready,
               bus.imem_rsp_valid, bus.imem_rsp_data);
    if (bus.imem_rsp_valid) mem_busy = 0;
    if (acc) begin mem_busy = 1; mem_cnt = lat; mem_addr = acc_addr; end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    mem_busy = 0;
  endtask

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    chk("req_valid", {31'h0, bus.imem_req_valid}, {31'h0, !m_out && !m_held});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
  end

  initial begin
    int k;
    stall_i = 0; flush_i = 0; jump_target_i = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    fixed_data_en = 1; force_rsp = 0; mem_cnt = 0; mem_addr = 0;
    assert_reset();
    repeat (2) cycle(0, 0, 0, 0, 1);
    rst_n = 1'b1;

    // First fetch after reset, latency 1
    chk("r33_addr0", bus.imem_addr, 32'h0040_0000);
    chk("r33_req0", {31'h0, bus.imem_req_valid}, 32'h1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("r33_instr", if_id_instr, 32'h2108_0001);
    chk("r33_pc4", if_id_pc_plus4, 32'h0040_0004);
    chk("r33_valid", {31'h0, if_id_valid}, 32'h1);
    chk("r33_addr1", bus.imem_addr, 32'h0040_0004);

    // Response lands under a 3-cycle stall
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 1);
      chk("r34_instr_hold", if_id_instr, 32'h2108_0001);
      chk("r34_pc4_hold", if_id_pc_plus4, 32'h0040_0004);
      chk("r34_no_req", {31'h0, bus.imem_req_valid}, 32'h0);
    end
    cycle(0, 0, 0, 1, 1);
    chk("r34_valid", {31'h0, if_id_valid}, 32'h1);
    chk("r34_pc4", if_id_pc_plus4, 32'h0040_0008);
    chk("r34_addr", bus.imem_addr, 32'h0040_0008);

    // Jump while the fetch is in flight
    cycle(0, 0, 0, 1, 2);
    cycle(0, 1, 32'h0040_0100, 1, 1);
    chk("r35_valid_f", {31'h0, if_id_valid}, 32'h0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("r36_addr_f", bus.imem_addr, 32'h0040_0008);
`else
    chk("r35_addr_f", bus.imem_addr, 32'h0040_0100);
`endif
    cycle(0, 0, 0, 1, 1);
    chk("r35_addr", bus.imem_addr, 32'h0040_0100);
    chk("r35_req", {31'h0, bus.imem_req_valid}, 32'h1);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("r36_valid", {31'h0, if_id_valid}, 32'h1);
    chk("r36_pc4", if_id_pc_plus4, 32'h0040_000C);
`else
    chk("r35_valid", {31'h0, if_id_valid}, 32'h0);
`endif

    // Flush under stall is ignored
    cycle(1, 1, 32'h1234_0000, 0, 1);
    chk("r37_addr", bus.imem_addr, 32'h0040_0100);
    chk("r37_instr", if_id_instr, 32'h2108_0001);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("r37_valid", {31'h0, if_id_valid}, 32'h1);
`else
    chk("r37_valid", {31'h0, if_id_valid}, 32'h0);
`endif
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("r37_next", bus.imem_addr, 32'h0040_0104);

    // PC wrap at the top of the address space
    cycle(0, 1, 32'hFFFF_FFFC, 0, 1);
    k = 0;
    while (bus.imem_addr !== 32'hFFFF_FFFC && k < 20) begin
      cycle(0, 0, 0, 1, 1);
      k++;
    end
    chk("r38_reach_top", {31'h0, k < 20}, 32'h1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("r38_wrap_addr", bus.imem_addr, 32'h0000_0000);
    chk("r38_wrap_pc4", if_id_pc_plus4, 32'h0000_0000);

    // Reset while waiting on a response
    cycle(0, 0, 0, 1, 3);
    assert_reset();
    #1;
    chk("r38_rst_addr", bus.imem_addr, RESET_PC);
    chk("r38_rst_req", {31'h0, bus.imem_req_valid}, 32'h1);
    chk("r38_rst_instr", if_id_instr, 32'h0);
    chk("r38_rst_pc4", if_id_pc_plus4, 32'h0);
    chk("r38_rst_valid", {31'h0, if_id_valid}, 32'h0);
    cycle(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    force_rsp = 1;
    cycle(0, 0, 0, 0, 1);
    force_rsp = 0;
    chk("r30_stale_valid", {31'h0, if_id_valid}, 32'h0);
    chk("r30_stale_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic
    fixed_data_en = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        assert_reset();
        cycle(0, 0, 0, 0, 1);
        rst_n = 1'b1;
      end
      cycle(($urandom % 4) == 0, ($urandom % 10) == 0,
            ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC),
            ($urandom % 3) != 0, $urandom_range(1, 3));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
